// File: rtl/pwm_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_apb_ctrl
// Description : APB3 register block that configures and sequences a PWM core.
//               Software programs shadow registers (enables, prescaler,
//               period, per-channel duty). A CTRL write with UPD_REQ=1 arms
//               an update. The shadow set is then copied atomically to the
//               active outputs on the next PWM period boundary, or one cycle
//               later if every channel is currently disabled. Duty values are
//               clamped to the period as they are committed.
// Ports       : clk, rstn                  clock, async active-low reset
//               psel/penable/pwrite/paddr/ APB3 slave port, zero wait states
//               pwdata/prdata/pready/pslverr
//               period_end_i               period boundary pulse from core
//               enable_o, prescaler_o,     active configuration to core
//               pwm_period_o, duty_cycle_o
//               irq_o                      registered STATUS.DONE & IRQEN
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_apb_ctrl #(
    parameter int NCH     = 3,
    parameter int PADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [PADDR_W-1:0]   paddr,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    input  logic                 period_end_i,
    output logic [NCH-1:0]       enable_o,
    output logic [31:0]          prescaler_o,
    output logic [31:0]          pwm_period_o,
    output logic [NCH*32-1:0]    duty_cycle_o,
    output logic                 irq_o
);

    localparam int AW = PADDR_W - 2;

    // Word offsets of the register map (byte address >> 2)
    localparam logic [AW-1:0] c_word_ctrl   = AW'(0);
    localparam logic [AW-1:0] c_word_presc  = AW'(1);
    localparam logic [AW-1:0] c_word_period = AW'(2);
    localparam logic [AW-1:0] c_word_status = AW'(8);
    localparam logic [AW-1:0] c_word_irqen  = AW'(9);
    localparam int            c_duty_base   = 3;
    localparam int            c_upd_bit     = 8;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Shadow (software-visible) registers
    logic [NCH-1:0] r_sh_en;
    logic [31:0]    r_sh_presc;
    logic [31:0]    r_sh_period;
    logic [31:0]    r_sh_duty [NCH];

    // Status / interrupt
    logic           r_done;
    logic           r_irqen;
    logic           r_irq;

    // Active registers driving the core
    logic [NCH-1:0]     r_en;
    logic [31:0]        r_presc;
    logic [31:0]        r_period;
    logic [NCH*32-1:0]  r_duty;

    // Decode
    logic [AW-1:0]  w_word;
    logic           w_access;
    logic           w_wr;
    logic           w_hit_ctrl;
    logic           w_hit_presc;
    logic           w_hit_period;
    logic           w_hit_status;
    logic           w_hit_irqen;
    logic [NCH-1:0] w_duty_sel;
    logic           w_hit_duty;
    logic           w_mapped;
    logic           w_shadow_hit;
    logic           w_err;
    logic           w_wr_ok;
    logic           w_upd_req;
    logic           w_commit;
    logic [NCH*32-1:0] w_duty_clamp;
    logic [31:0]    w_duty_rd;
    logic           w_unused;

    assign w_word   = paddr[PADDR_W-1:2];
    assign w_access = psel & penable;
    assign w_wr     = w_access & pwrite;

    assign w_hit_ctrl   = (w_word == c_word_ctrl);
    assign w_hit_presc  = (w_word == c_word_presc);
    assign w_hit_period = (w_word == c_word_period);
    assign w_hit_status = (w_word == c_word_status);
    assign w_hit_irqen  = (w_word == c_word_irqen);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_duty_dec
            assign w_duty_sel[i] = (w_word == AW'(c_duty_base + i));
        end
    endgenerate

    assign w_hit_duty   = |w_duty_sel;
    assign w_mapped     = w_hit_ctrl | w_hit_presc | w_hit_period | w_hit_duty |
                          w_hit_status | w_hit_irqen;
    assign w_shadow_hit = w_hit_ctrl | w_hit_presc | w_hit_period | w_hit_duty;

    // Errors: unmapped access, shadow write while an update is armed, or an
    // update request against a zero period. STATUS/IRQEN never error.
    assign w_err = w_access & (
                       ~w_mapped
                     | (pwrite & w_shadow_hit & (r_state == S_PENDING))
                     | (pwrite & w_hit_ctrl & pwdata[c_upd_bit] & (r_sh_period == 32'd0)));

    assign w_wr_ok   = w_wr & ~w_err;
    assign w_upd_req = w_wr_ok & w_hit_ctrl & pwdata[c_upd_bit];

    assign pready  = 1'b1;
    assign pslverr = w_err;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_upd_req) begin
                    w_state_nxt = S_PENDING;
                end
            end
            S_PENDING: begin
                // A stopped core never produces period_end_i, so commit at once.
                if (period_end_i || (r_en == '0)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sh_en     <= '0;
            r_sh_presc  <= '0;
            r_sh_period <= '0;
        end else if (w_wr_ok) begin
            if (w_hit_ctrl)   r_sh_en     <= pwdata[NCH-1:0];
            if (w_hit_presc)  r_sh_presc  <= pwdata;
            if (w_hit_period) r_sh_period <= pwdata;
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_shadow_duty
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_sh_duty[i] <= '0;
                end else if (w_wr_ok && w_duty_sel[i]) begin
                    r_sh_duty[i] <= pwdata;
                end
            end

            // Clamp is applied only on the path into the active registers;
            // the shadow copy keeps whatever software wrote.
            assign w_duty_clamp[32*i +: 32] = (r_sh_duty[i] > r_sh_period) ?
                                              r_sh_period : r_sh_duty[i];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Active registers: change only on a commit edge, all fields together
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_en     <= '0;
            r_presc  <= '0;
            r_period <= '0;
            r_duty   <= '0;
        end else if (w_commit) begin
            r_en     <= r_sh_en;
            r_presc  <= r_sh_presc;
            r_period <= r_sh_period;
            r_duty   <= w_duty_clamp;
        end
    end

    // ------------------------------------------------------------------
    // STATUS.DONE, IRQEN and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done  <= 1'b0;
            r_irqen <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= r_done & r_irqen;
            if (w_wr_ok && w_hit_irqen) begin
                r_irqen <= pwdata[0];
            end
            // A commit on the same edge as a W1C keeps DONE set.
            if (w_commit) begin
                r_done <= 1'b1;
            end else if (w_wr_ok && w_hit_status && pwdata[1]) begin
                r_done <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_duty_rd = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_duty_sel[i]) begin
                w_duty_rd = w_duty_rd | r_sh_duty[i];
            end
        end
    end

    always_comb begin
        prdata = '0;
        if (w_hit_ctrl) begin
            prdata = 32'(r_sh_en);
        end else if (w_hit_presc) begin
            prdata = r_sh_presc;
        end else if (w_hit_period) begin
            prdata = r_sh_period;
        end else if (w_hit_duty) begin
            prdata = w_duty_rd;
        end else if (w_hit_status) begin
            prdata = {30'd0, r_done, (r_state == S_PENDING)};
        end else if (w_hit_irqen) begin
            prdata = {31'd0, r_irqen};
        end
    end

    assign enable_o     = r_en;
    assign prescaler_o  = r_presc;
    assign pwm_period_o = r_period;
    assign duty_cycle_o = r_duty;
    assign irq_o        = r_irq;

    // Byte-lane bits of paddr and upper CTRL data bits carry no function.
    assign w_unused = ^{paddr[1:0], pwdata};

endmodule
`default_nettype wire
